// File: rtl/regfile_io.sv
// regfile_io: picoMIPS register file with memory-mapped input/output ports.
// Define REGFILE_BYPASS_EN to forward write_data to same-cycle reads.
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef REGISTERS_SIZE
`define REGISTERS_SIZE 3
`endif

module regfile_io #(
   parameter int n              = `DATA_BUS_SIZE,
   parameter int registers_size = `REGISTERS_SIZE,
   parameter int NIN            = 1,
   parameter int NOUT           = 1,
   localparam int NI            = (NIN > 0) ? NIN : 1,
   localparam int NO            = (NOUT > 0) ? NOUT : 1,
   localparam int IW            = NI * n,
   localparam int OW            = NO * n
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      w,
   input  logic [registers_size-1:0] w_addr,
   input  logic [n-1:0]              write_data,
   input  logic [registers_size-1:0] ra_addr,
   input  logic [registers_size-1:0] rb_addr,
   output logic [n-1:0]              ra_data,
   output logic [n-1:0]              rb_data,
   input  logic [IW-1:0]             inport,
   output logic [OW-1:0]             outport,
   output logic [NO-1:0]             out_stb
);

   localparam int NR   = 1 << registers_size;
   localparam int GPR0 = 1 + NIN + NOUT;

   if (NIN < 0 || NOUT < 0 || GPR0 > NR) begin : g_bad_map
      $error("regfile_io: port map does not fit the address space");
   end

   logic [n-1:0] gpr  [NR];
   logic [n-1:0] s1   [NI];
   logic [n-1:0] s2   [NI];
   logic [n-1:0] outq [NO];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) gpr[i] <= '0;
         for (int k = 0; k < NI; k++) begin
            s1[k] <= '0;
            s2[k] <= '0;
         end
         for (int k = 0; k < NO; k++) outq[k] <= '0;
         out_stb <= '0;
      end else begin
         out_stb <= '0;
         for (int k = 0; k < NIN; k++) begin
            s1[k] <= inport[k*n +: n];
            s2[k] <= s1[k];
         end
         if (w) begin
            for (int k = 0; k < NOUT; k++)
               if (w_addr == registers_size'(1 + NIN + k)) begin
                  outq[k]    <= write_data;
                  out_stb[k] <= 1'b1;
               end
            for (int i = GPR0; i < NR; i++)
               if (w_addr == registers_size'(i))
                  gpr[i] <= write_data;
         end
      end
   end

   // Zero and input addresses are never forwarded; they have no storage.
   function automatic logic [n-1:0] rd(
      input logic [registers_size-1:0] a
   );
      logic [n-1:0] v;
      v = '0;
      for (int k = 0; k < NIN; k++)
         if (a == registers_size'(1 + k)) v = s2[k];
      for (int k = 0; k < NOUT; k++)
         if (a == registers_size'(1 + NIN + k)) v = outq[k];
      for (int i = GPR0; i < NR; i++)
         if (a == registers_size'(i)) v = gpr[i];
`ifdef REGFILE_BYPASS_EN
      if (w && a == w_addr && int'(a) > NIN) v = write_data;
`else
`endif
      return v;
   endfunction

   always_comb begin
      ra_data = rd(ra_addr);
      rb_data = rd(rb_addr);
   end

   always_comb begin
      outport = '0;
      for (int k = 0; k < NOUT; k++)
         outport[k*n +: n] = outq[k];
   end

endmodule

// File: tb/tb_regfile_io.sv
// tb_regfile_io: directed and random checks of regfile_io against
// an address-map model (n=8, 3-bit addresses, plus a 2-in/2-out sweep).
module tb_regfile_io;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, w;
   logic [2:0] w_addr, ra_addr, rb_addr;
   logic [7:0] write_data, ra_data, rb_data, inport, outport;
   logic [0:0] out_stb;

   regfile_io #(.n(8), .registers_size(3), .NIN(1), .NOUT(1)) dut (
      .clk(clk), .reset(reset), .w(w), .w_addr(w_addr),
      .write_data(write_data), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data), .rb_data(rb_data), .inport(inport),
      .outport(outport), .out_stb(out_stb)
   );

   logic        reset2, w2;
   logic [2:0]  wa2, ra2, rb2;
   logic [7:0]  wd2, rd2a, rd2b;
   logic [15:0] in2, out2;
   logic [1:0]  stb2;

   regfile_io #(.n(8), .registers_size(3), .NIN(2), .NOUT(2)) dut2 (
      .clk(clk), .reset(reset2), .w(w2), .w_addr(wa2),
      .write_data(wd2), .ra_addr(ra2), .rb_addr(rb2),
      .ra_data(rd2a), .rb_data(rd2b), .inport(in2),
      .outport(out2), .out_stb(stb2)
   );

   int checks = 0;
   int failures = 0;

   // Model: m[2] is the output port, m[3..7] GPRs; q1/q2 the sync stages.
   logic [7:0] m [8];
   logic [7:0] q1, q2;
   logic       mstb;
   bit         known = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_rd(input logic [2:0] a);
      if (a == 3'd0) return 8'h00;
      if (a == 3'd1) return q2;
`ifdef REGFILE_BYPASS_EN
      if (w && w_addr == a) return write_data;
`endif
      return m[a];
   endfunction

   task automatic drive(input bit rs, input bit we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic [2:0] ra,
                        input logic [2:0] rb);
      reset = rs;
      w = we;
      w_addr = wa;
      write_data = wd;
      ra_addr = ra;
      rb_addr = rb;
      #1;
      if (known) begin
         chk("ra_data", {8'h0, ra_data}, {8'h0, exp_rd(ra_addr)});
         chk("rb_data", {8'h0, rb_data}, {8'h0, exp_rd(rb_addr)});
         chk("outport", {8'h0, outport}, {8'h0, m[2]});
         chk("out_stb", {15'h0, out_stb}, {15'h0, mstb});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) m[i] = 8'h00;
         q1 = 8'h00;
         q2 = 8'h00;
         mstb = 1'b0;
         known = 1'b1;
      end else begin
         mstb = 1'b0;
         q2 = q1;
         q1 = inport;
         if (w && w_addr == 3'd2) begin
            m[2] = write_data;
            mstb = 1'b1;
         end else if (w && w_addr >= 3'd3) begin
            m[w_addr] = write_data;
         end
      end
      #1;
   endtask

   initial begin
      logic [7:0] byp;
      inport = 8'h00;
      reset2 = 1'b1; w2 = 1'b0; wa2 = 3'd0; wd2 = 8'h00;
      ra2 = 3'd0; rb2 = 3'd0; in2 = 16'h0000;

      // Reset discards r5 contents and a concurrent output write.
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(0, 1, 5, 8'hAA, 0, 0); tick();
      drive(1, 1, 2, 8'h99, 5, 5); tick();
      drive(0, 0, 0, 0, 5, 5);
      chk("rst_r5", {8'h0, rb_data}, 16'h0000);
      chk("rst_out", {8'h0, outport}, 16'h0000);
      chk("rst_stb", {15'h0, out_stb}, 16'h0000);
      tick();

      // GPR write/read and ignored writes to zero/input addresses.
      inport = 8'h42;
      drive(0, 1, 4, 8'h3C, 0, 0); tick();
      drive(0, 1, 7, 8'hC3, 0, 0); tick();
      drive(0, 0, 0, 0, 4, 7);
      chk("gpr_r4", {8'h0, ra_data}, 16'h003C);
      chk("gpr_r7", {8'h0, rb_data}, 16'h00C3);
      tick();
      drive(0, 1, 0, 8'hFF, 0, 0); tick();
      drive(0, 1, 1, 8'hFF, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 1);
      chk("r0_zero", {8'h0, ra_data}, 16'h0000);
      chk("r1_in", {8'h0, rb_data}, 16'h0042);
      tick();

      // Output write: one-cycle strobe, value held afterwards.
      drive(0, 1, 2, 8'h5A, 2, 2); tick();
      drive(0, 0, 0, 0, 2, 2);
      chk("out_val", {8'h0, outport}, 16'h005A);
      chk("out_stb1", {15'h0, out_stb}, 16'h0001);
      chk("out_rd", {8'h0, ra_data}, 16'h005A);
      tick();
      drive(0, 0, 0, 0, 2, 2);
      chk("out_stb0", {15'h0, out_stb}, 16'h0000);
      chk("out_hold", {8'h0, outport}, 16'h005A);
      tick();

      // Two-flop input latency.
      inport = 8'h00;
      drive(0, 0, 0, 0, 1, 1); tick();
      drive(0, 0, 0, 0, 1, 1); tick();
      inport = 8'h81;
      drive(0, 0, 0, 0, 1, 1);
      chk("in_pre", {8'h0, ra_data}, 16'h0000);
      tick();
      drive(0, 0, 0, 0, 1, 1);
      chk("in_t", {8'h0, ra_data}, 16'h0000);
      tick();
      drive(0, 0, 0, 0, 1, 1);
      chk("in_t1", {8'h0, ra_data}, 16'h0081);
      tick();

      // Same-cycle write/read.
`ifdef REGFILE_BYPASS_EN
      byp = 8'h77;
`else
      byp = 8'h00;
`endif
      drive(0, 1, 6, 8'h77, 6, 6);
      chk("byp_same", {8'h0, ra_data}, {8'h0, byp});
      tick();
      drive(0, 0, 0, 0, 6, 6);
      chk("byp_next", {8'h0, ra_data}, 16'h0077);
      tick();
      drive(0, 1, 1, 8'h33, 1, 1);
      chk("byp_in", {8'h0, ra_data}, 16'h0081);
      tick();

      // Random traffic against the model.
      repeat (400) begin
         inport = 8'($urandom);
         drive(($urandom_range(0, 31) == 0), 1'($urandom),
               3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
         tick();
      end

      // Two inputs, two outputs: 1-2 in, 3-4 out, 5-7 GPR.
      drive(0, 0, 0, 0, 0, 0);
      reset2 = 1'b1;
      tick();
      reset2 = 1'b0;
      w2 = 1'b1; wa2 = 3'd3; wd2 = 8'h11; in2 = 16'hB2A1;
      tick();
      chk("sw_out0", out2, 16'h0011);
      chk("sw_stb0", {14'h0, stb2}, 16'h0001);
      wa2 = 3'd4; wd2 = 8'h22;
      tick();
      chk("sw_out1", out2, 16'h2211);
      chk("sw_stb1", {14'h0, stb2}, 16'h0002);
      w2 = 1'b0; ra2 = 3'd2; rb2 = 3'd1;
      tick();
      chk("sw_in1", {8'h0, rd2a}, 16'h00B2);
      chk("sw_in0", {8'h0, rd2b}, 16'h00A1);
      chk("sw_stbz", {14'h0, stb2}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
